mem_bridge: RTL
===============

Name: mem_bridge

Overview:
- Memory-side neighbour of the multi-cycle controller/datapath.
- Converts the core's single-cycle read/write strobes into a req/ack handshake toward variable-latency external memory.
- Stalls the controller's cycle counter until the access completes, and returns read data in a holding register for the MDR/IR path.
- Detects misaligned addresses, conflicting strobes and ack timeouts.

Parameters:
- ADDR_WIDTH, 16, byte address width (16-bit architecture).
- DATA_WIDTH, 16, word width.
- TIMEOUT, 15, maximum number of cycles ext_req is held without ext_ack; must be >= 1.
- TO_WIDTH, 4, width of the timeout counter; must hold TIMEOUT-1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_req  in  1  core read strobe (PC fetch or data load).
- wr_req  in  1  core write strobe (store).
- req_addr  in  ADDR_WIDTH  core byte address.
- req_wdata  in  DATA_WIDTH  store data.
- stall  out  1  combinational; holds the controller's cycle counter.
- rdata  out  DATA_WIDTH  registered read data.
- done  out  1  one-cycle pulse: access completed.
- err  out  1  one-cycle pulse: request rejected or timed out.
- err_sticky  out  1  latched error flag.
- err_clr  in  1  clears err_sticky.
- ext_req  out  1  external request, registered.
- ext_we  out  1  external write enable, registered.
- ext_addr  out  ADDR_WIDTH  external address, registered.
- ext_wdata  out  DATA_WIDTH  external write data, registered.
- ext_ack  in  1  external completion; sampled only while ext_req = 1.
- ext_rdata  in  DATA_WIDTH  valid in any cycle where ext_ack = 1 and ext_we = 0.

Behaviour:
- Reset (asynchronous, active-high), outputs held while rst = 1:
  - state = IDLE.
  - All registered outputs = 0: ext_req, ext_we, ext_addr, ext_wdata, rdata, done, err, err_sticky, timeout counter.
- States: IDLE and ACCESS only.
- Acceptance in IDLE: a request (rd_req or wr_req) is valid if exactly one strobe is high and req_addr[0] = 0.
- Valid request in IDLE:
  - stall = 1 in that same cycle.
  - At the clock edge: latch req_addr, req_wdata and wr_req into ext_addr, ext_wdata, ext_we; set ext_req = 1; clear the counter; go to ACCESS.
- Invalid request in IDLE (both strobes high, or address odd):
  - No external access; state stays IDLE; stall = 0.
  - err pulses high in the next cycle; err_sticky set.
- ACCESS:
  - stall = 1 for every cycle spent here.
  - ext_req, ext_we, ext_addr and ext_wdata are held stable until the state exits.
  - Core strobes are ignored.
- ext_ack = 1 in ACCESS:
  - At the edge: ext_req = 0, state = IDLE, done = 1 in the following cycle.
  - If ext_we = 0, rdata <= ext_rdata.
  - Writes leave rdata unchanged.
- No ack in ACCESS:
  - If counter == TIMEOUT-1: abort at the edge (ext_req = 0, state = IDLE), err pulse and err_sticky set next cycle, no done, rdata unchanged.
  - Otherwise counter++.
  - So ext_req is high for exactly TIMEOUT cycles on a timeout.
  - An ack arriving in the final counted cycle wins over the timeout.
- Latency:
  - Request seen in cycle t → ext_req high from t+1.
  - Ack seen in cycle t+k → done and new rdata visible in t+k+1.
  - stall high in cycles t through t+k.
  - A zero-wait memory (ack in t+1) gives 2 stall cycles.
- Back-to-back: in the done cycle the state is IDLE, so a new request is accepted with no bubble.
- rdata holds its value until the next successful read.
- done and err are never high in the same cycle.
- ext_ack while in IDLE is ignored.
- err_sticky:
  - Set by any err event.
  - Cleared by err_clr at the clock edge.
  - Set wins if an err event and err_clr coincide.
- Reset mid-access: ext_req drops immediately (asynchronous reset); any pending ack is ignored afterwards.

Test Plan:
- Read, zero-wait: rd_req with req_addr = 0x0010; memory acks in the first ext_req cycle with ext_rdata = 0xBEEF → ext_addr = 0x0010, ext_we = 0, stall high 2 cycles, done pulse on the 3rd cycle, rdata = 0xBEEF.
- Write, 3 wait cycles: wr_req with addr 0x0020, wdata 0x1234; ack on the 4th ext_req cycle → ext_we = 1 and ext_wdata = 0x1234 stable for all 4 cycles, stall high 5 cycles, done pulse, rdata unchanged.
- Timeout with TIMEOUT = 15: read with ack never asserted → ext_req high exactly 15 cycles, then err pulse, err_sticky = 1, no done, rdata retains its prior value. Apply err_clr → err_sticky = 0.
- Invalid requests: rd_req with addr 0x0011, then rd_req and wr_req together with addr 0x0040 → no ext_req for either, stall = 0, err pulses, err_sticky = 1.
- Back-to-back with edge timing:
  - Read 0x0002 completes; a new rd_req 0x0004 is applied in its done cycle → accepted immediately, with ext_req high the next cycle.
  - Separately, an ack arriving on cycle 15 (TIMEOUT = 15) → done, not err.
- Reset mid-access: assert rst while ext_req = 1 → ext_req, stall and all outputs go to 0 asynchronously. A later ext_ack after rst releases → ignored, no done.

Source files
------------

// File: rtl/mem_bridge.sv
`default_nettype none
// ============================================================================
// mem_bridge : core read/write strobes to req/ack external memory, with timeout
// Revision   : 1.0
// ============================================================================
module mem_bridge #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int TIMEOUT    = 15,
   parameter int TO_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_req,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  stall,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  done,
   output logic                  err,
   output logic                  err_sticky,
   input  logic                  err_clr,
   output logic                  ext_req,
   output logic                  ext_we,
   output logic [ADDR_WIDTH-1:0] ext_addr,
   output logic [DATA_WIDTH-1:0] ext_wdata,
   input  logic                  ext_ack,
   input  logic [DATA_WIDTH-1:0] ext_rdata
);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   localparam logic [TO_WIDTH-1:0] c_CNT_LAST = TO_WIDTH'(TIMEOUT - 1);

   state_t                state_q;
   logic                  ext_req_q;
   logic                  ext_we_q;
   logic [ADDR_WIDTH-1:0] ext_addr_q;
   logic [DATA_WIDTH-1:0] ext_wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  done_q;
   logic                  err_q;
   logic                  err_sticky_q;
   logic [TO_WIDTH-1:0]   cnt_q;

   logic                  w_req_any;
   logic                  w_req_valid;

   assign w_req_any   = rd_req | wr_req;
   assign w_req_valid = (rd_req ^ wr_req) & ~req_addr[0];

   // Stall is forced low during reset so the controller is released at once.
   assign stall = ~rst & ((state_q == S_ACCESS) | ((state_q == S_IDLE) & w_req_valid));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ext_req_q    <= 1'b0;
         ext_we_q     <= 1'b0;
         ext_addr_q   <= '0;
         ext_wdata_q  <= '0;
         rdata_q      <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         err_sticky_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (err_clr) begin
            err_sticky_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (w_req_valid) begin
                  ext_addr_q  <= req_addr;
                  ext_wdata_q <= req_wdata;
                  ext_we_q    <= wr_req;
                  ext_req_q   <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= S_ACCESS;
               end else if (w_req_any) begin
                  // Later assignment lets a new error win over err_clr.
                  err_q        <= 1'b1;
                  err_sticky_q <= 1'b1;
               end
            end
            S_ACCESS: begin
               if (ext_ack) begin
                  ext_req_q <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= S_IDLE;
                  if (!ext_we_q) begin
                     rdata_q <= ext_rdata;
                  end
               end else if (cnt_q == c_CNT_LAST) begin
                  ext_req_q    <= 1'b0;
                  err_q        <= 1'b1;
                  err_sticky_q <= 1'b1;
                  state_q      <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + TO_WIDTH'(1);
               end
            end
            default: begin
               state_q   <= S_IDLE;
               ext_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign rdata      = rdata_q;
   assign done       = done_q;
   assign err        = err_q;
   assign err_sticky = err_sticky_q;
   assign ext_req    = ext_req_q;
   assign ext_we     = ext_we_q;
   assign ext_addr   = ext_addr_q;
   assign ext_wdata  = ext_wdata_q;

endmodule
`default_nettype wire
